// File: rtl/hazard_ctrl_pipe.sv
// Hazard unit: N-operand EX forwarding, multi-cycle load stall,
// multi-cycle branch flush and saturating stall/flush counters.
module hazard_ctrl_pipe #(
   parameter int DATA_W       = 32,
   parameter int REG_AW       = 4,
   parameter int NUM_SRC      = 3,
   parameter int LOAD_LAT     = 2,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC*REG_AW-1:0]  src_addr,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic                       mem_valid,
   input  logic [REG_AW-1:0]          mem_rd,
   input  logic                       mem_regwrite,
   input  logic                       mem_is_load,
   input  logic [REG_AW-1:0]          wb_rd,
   input  logic                       wb_regwrite,
   input  logic [DATA_W-1:0]          alu_result,
   input  logic [DATA_W-1:0]          wb_result,
   input  logic                       branch_taken,
   output logic [NUM_SRC-1:0]         fwd_en,
   output logic [NUM_SRC*DATA_W-1:0]  fwd_data,
   output logic [4:0]                 stall,
   output logic [4:0]                 flush,
   output logic [CNT_W-1:0]           stall_count,
   output logic [CNT_W-1:0]           flush_count
);

   typedef enum logic [1:0] {IDLE, LD_WAIT, BR_FLUSH} state_e;

   localparam bit          LD_MULTI = (LOAD_LAT > 1);
   localparam bit          BR_MULTI = (FLUSH_CYCLES > 1);
   localparam logic [7:0]  LD_INIT  = 8'(LD_MULTI ? LOAD_LAT - 2 : 0);
   localparam logic [7:0]  BR_INIT  = 8'(BR_MULTI ? FLUSH_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [4:0]        stall_c, flush_c;
   logic              br_evt, load_use;
   logic [NUM_SRC-1:0] hit_mem, hit_wb, lu_hit;

   always_comb begin
      hit_mem  = '0;
      hit_wb   = '0;
      lu_hit   = '0;
      fwd_en   = '0;
      fwd_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         hit_mem[i] = src_valid[i] & mem_valid & mem_regwrite & ~mem_is_load
                    & (mem_rd == src_addr[i*REG_AW +: REG_AW]);
         hit_wb[i]  = src_valid[i] & wb_regwrite
                    & (wb_rd == src_addr[i*REG_AW +: REG_AW]);
         lu_hit[i]  = src_valid[i] & mem_valid & mem_is_load & mem_regwrite
                    & (mem_rd == src_addr[i*REG_AW +: REG_AW]);
         fwd_en[i]  = hit_mem[i] | hit_wb[i];
         if (hit_mem[i])
            fwd_data[i*DATA_W +: DATA_W] = alu_result;
         else if (hit_wb[i])
            fwd_data[i*DATA_W +: DATA_W] = wb_result;
      end
   end

   assign load_use = |lu_hit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_c = '0;
      flush_c = '0;
      br_evt  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (branch_taken) begin
               flush_c = 5'b01110;
               br_evt  = 1'b1;
               if (BR_MULTI) begin
                  cnt_d   = BR_INIT;
                  state_d = BR_FLUSH;
               end
            end else if (mem_valid && mem_is_load && LD_MULTI) begin
               stall_c = 5'b01111;
               flush_c = 5'b10000;
               cnt_d   = LD_INIT;
               state_d = LD_WAIT;
            end else if (load_use) begin
               stall_c = 5'b00111;
               flush_c = 5'b01000;
            end
         end
         LD_WAIT: begin
            if (cnt_q != 8'd0) begin
               stall_c = 5'b01111;
               flush_c = 5'b10000;
               cnt_d   = cnt_q - 8'd1;
            end else begin
               state_d = IDLE;
               if (load_use) begin
                  stall_c = 5'b00111;
                  flush_c = 5'b01000;
               end
            end
         end
         BR_FLUSH: begin
            flush_c = 5'b00010;
            if (cnt_q == 8'd0)
               state_d = IDLE;
            else
               cnt_d = cnt_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset silences the pipeline controls at once, not on the next edge.
   assign stall = rst ? 5'b0 : stall_c;
   assign flush = rst ? 5'b0 : flush_c;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((|stall) && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + ONE;
      if (br_evt && !(&flush_cnt_q))
         flush_cnt_d = flush_cnt_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe; three instances cover
// LOAD_LAT=1, LOAD_LAT=3/FLUSH_CYCLES=3 and LOAD_LAT=4/CNT_W=2.
module tb_hazard_ctrl_pipe;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NS = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NS*AW-1:0] src_addr;
   logic [NS-1:0]    src_valid;
   logic             mem_valid, mem_regwrite, mem_is_load, wb_regwrite;
   logic [AW-1:0]    mem_rd, wb_rd;
   logic [DW-1:0]    alu_result, wb_result;
   logic             branch_taken;

   logic [NS-1:0]    fe1, fe3, fe4;
   logic [NS*DW-1:0] fd1, fd3, fd4;
   logic [4:0]       st1, st3, st4, fl1, fl3, fl4;
   logic [15:0]      sc1, fc1, sc3, fc3;
   logic [1:0]       sc4, fc4;

   hazard_ctrl_pipe #(.LOAD_LAT(1), .FLUSH_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .src_addr(src_addr), .src_valid(src_valid),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .mem_is_load(mem_is_load), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .alu_result(alu_result), .wb_result(wb_result),
      .branch_taken(branch_taken), .fwd_en(fe1), .fwd_data(fd1),
      .stall(st1), .flush(fl1), .stall_count(sc1), .flush_count(fc1));

   hazard_ctrl_pipe #(.LOAD_LAT(3), .FLUSH_CYCLES(3)) u3 (
      .clk(clk), .rst(rst), .src_addr(src_addr), .src_valid(src_valid),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .mem_is_load(mem_is_load), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .alu_result(alu_result), .wb_result(wb_result),
      .branch_taken(branch_taken), .fwd_en(fe3), .fwd_data(fd3),
      .stall(st3), .flush(fl3), .stall_count(sc3), .flush_count(fc3));

   hazard_ctrl_pipe #(.LOAD_LAT(4), .FLUSH_CYCLES(1), .CNT_W(2)) u4 (
      .clk(clk), .rst(rst), .src_addr(src_addr), .src_valid(src_valid),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .mem_is_load(mem_is_load), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .alu_result(alu_result), .wb_result(wb_result),
      .branch_taken(branch_taken), .fwd_en(fe4), .fwd_data(fd4),
      .stall(st4), .flush(fl4), .stall_count(sc4), .flush_count(fc4));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      src_addr     = '0;
      src_valid    = '0;
      mem_valid    = 1'b0;
      mem_regwrite = 1'b0;
      mem_is_load  = 1'b0;
      mem_rd       = '0;
      wb_rd        = '0;
      wb_regwrite  = 1'b0;
      alu_result   = '0;
      wb_result    = '0;
      branch_taken = 1'b0;
   endtask

   task automatic do_reset();
      clr();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic load(input logic [AW-1:0] rd);
      mem_valid    = 1'b1;
      mem_is_load  = 1'b1;
      mem_regwrite = 1'b1;
      mem_rd       = rd;
   endtask

   initial begin
      clr();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_stall", 64'(st1), 64'h0);
      chk("rst_flush", 64'(fl3), 64'h0);
      chk("rst_sc", 64'(sc3), 64'h0);
      chk("rst_fc", 64'(fc4), 64'h0);
      rst = 1'b0;

      // forwarding priority and qualifiers
      src_addr[3:0] = 4'd1;
      src_valid     = 3'b001;
      mem_valid     = 1'b1;
      mem_rd        = 4'd1;
      mem_regwrite  = 1'b1;
      alu_result    = 32'd10;
      wb_rd         = 4'd1;
      wb_regwrite   = 1'b1;
      wb_result     = 32'd2;
      #1;
      chk("fwd_en_mem", 64'(fe1), 64'h1);
      chk("fwd_mem_pri", 64'(fd1[31:0]), 64'd10);
      chk("fwd_hi_zero", 64'(fd1[95:32]), 64'h0);
      mem_regwrite = 1'b0;
      #1;
      chk("fwd_wb", 64'(fd1[31:0]), 64'd2);
      mem_regwrite = 1'b1;
      mem_is_load  = 1'b1;
      #1;
      chk("fwd_ld_no_mem", 64'(fd1[31:0]), 64'd2);
      chk("lu_stall_comb", 64'(st1), 64'h07);
      mem_is_load = 1'b0;
      src_valid   = 3'b000;
      #1;
      chk("fwd_invalid_en", 64'(fe1), 64'h0);
      chk("fwd_invalid_dat", 64'(fd1[31:0]), 64'h0);
      src_addr[3:0] = 4'd0;
      src_valid     = 3'b001;
      mem_valid     = 1'b0;
      wb_rd         = 4'd0;
      #1;
      chk("fwd_r0_en", 64'(fe1), 64'h1);
      chk("fwd_r0_dat", 64'(fd1[31:0]), 64'd2);

      // load-use with single-cycle load
      do_reset();
      load(4'd2);
      src_addr[7:4] = 4'd2;
      src_valid     = 3'b010;
      #1;
      chk("lu_stall", 64'(st1), 64'h07);
      chk("lu_flush", 64'(fl1), 64'h08);
      tick();
      mem_valid   = 1'b0;
      mem_is_load = 1'b0;
      wb_rd       = 4'd2;
      wb_regwrite = 1'b1;
      wb_result   = 32'd7;
      #1;
      chk("lu_release", 64'(st1), 64'h0);
      chk("lu_fwd_en", 64'(fe1), 64'h2);
      chk("lu_fwd_dat", 64'(fd1[63:32]), 64'd7);
      chk("lu_sc", 64'(sc1), 64'd1);

      // single-cycle branch flush
      branch_taken = 1'b1;
      #1;
      chk("br1_flush", 64'(fl1), 64'h0e);
      tick();
      branch_taken = 1'b0;
      #1;
      chk("br1_done", 64'(fl1), 64'h0);
      chk("br1_fc", 64'(fc1), 64'd1);

      // LOAD_LAT=3 latency stall
      do_reset();
      load(4'd5);
      #1;
      chk("ld3_c1_stall", 64'(st3), 64'h0f);
      chk("ld3_c1_flush", 64'(fl3), 64'h10);
      tick();
      chk("ld3_c2_stall", 64'(st3), 64'h0f);
      chk("ld3_c2_flush", 64'(fl3), 64'h10);
      tick();
      chk("ld3_rel_stall", 64'(st3), 64'h0);
      chk("ld3_rel_flush", 64'(fl3), 64'h0);
      chk("ld3_sc", 64'(sc3), 64'd2);
      mem_valid = 1'b0;
      tick();
      chk("ld3_idle", 64'(st3), 64'h0);
      chk("ld3_sc_hold", 64'(sc3), 64'd2);

      // FLUSH_CYCLES=3 branch with a load arriving during the flush
      do_reset();
      branch_taken = 1'b1;
      #1;
      chk("br3_c1_flush", 64'(fl3), 64'h0e);
      tick();
      branch_taken = 1'b0;
      load(4'd3);
      src_addr[3:0] = 4'd3;
      src_valid     = 3'b001;
      #1;
      chk("br3_c2_flush", 64'(fl3), 64'h02);
      chk("br3_c2_stall", 64'(st3), 64'h0);
      tick();
      chk("br3_c3_flush", 64'(fl3), 64'h02);
      chk("br3_c3_stall", 64'(st3), 64'h0);
      tick();
      clr();
      #1;
      chk("br3_end_flush", 64'(fl3), 64'h0);
      chk("br3_fc", 64'(fc3), 64'd1);
      chk("br3_sc", 64'(sc3), 64'd0);

      // reset in the middle of a LOAD_LAT=4 stall
      do_reset();
      load(4'd5);
      #1;
      chk("rld_c1_stall", 64'(st4), 64'h0f);
      tick();
      chk("rld_sc", 64'(sc4), 64'd1);
      rst           = 1'b1;
      src_addr[3:0] = 4'd6;
      src_valid     = 3'b001;
      wb_rd         = 4'd6;
      wb_regwrite   = 1'b1;
      wb_result     = 32'd9;
      #1;
      chk("rld_rst_stall", 64'(st4), 64'h0);
      chk("rld_rst_flush", 64'(fl4), 64'h0);
      chk("rld_rst_fwd", 64'(fd4[31:0]), 64'd9);
      tick();
      rst = 1'b0;
      clr();
      #1;
      chk("rld_post_stall", 64'(st4), 64'h0);
      chk("rld_post_sc", 64'(sc4), 64'd0);
      chk("rld_post_fc", 64'(fc4), 64'd0);

      // continuous stall saturating a 2-bit counter
      do_reset();
      load(4'd3);
      src_addr[3:0] = 4'd3;
      src_valid     = 3'b001;
      for (int k = 1; k <= 5; k++) begin
         #1;
         chk($sformatf("sat_stall_%0d", k), 64'(st4),
             (k == 4) ? 64'h07 : 64'h0f);
         tick();
         chk($sformatf("sat_cnt_%0d", k), 64'(sc4),
             (k > 3) ? 64'd3 : 64'(k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl_pipe.md
Name: hazard_ctrl_pipe

Overview:
- Parametrised successor to the 5-stage pipeline hazard unit.
- Forwards N source operands in EX from the EX/MEM and MEM/WB results.
- Handles multi-cycle data-memory loads (configurable latency) with a sequenced stall.
- Issues multi-cycle branch flushes and keeps saturating stall/flush performance counters.
- Sits beside the pipeline registers and drives their stall/flush controls.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 4, register address width
NUM_SRC, 3, source operands checked in EX
LOAD_LAT, 2, cycles a load occupies MEM (>=1)
FLUSH_CYCLES, 1, cycles of flush per taken branch (>=1)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
src_addr  in  NUM_SRC*REG_AW  EX-stage source registers; operand i at [i*REG_AW +: REG_AW]
src_valid  in  NUM_SRC  source i is actually read
mem_valid  in  1  EX/MEM holds a real instruction
mem_rd  in  REG_AW  EX/MEM destination
mem_regwrite  in  1  EX/MEM writes a register
mem_is_load  in  1  EX/MEM instruction is a load
wb_rd  in  REG_AW  MEM/WB destination
wb_regwrite  in  1  MEM/WB writes a register
alu_result  in  DATA_W  EX/MEM ALU result
wb_result  in  DATA_W  MEM/WB writeback value
branch_taken  in  1  taken branch resolved in MEM
fwd_en  out  NUM_SRC  operand i uses forwarded data
fwd_data  out  NUM_SRC*DATA_W  forwarded values, same packing as src_addr
stall  out  5  hold bit k: 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB
flush  out  5  bubble insert, same bit mapping
stall_count  out  CNT_W  cycles with any stall bit set
flush_count  out  CNT_W  taken-branch flush events

Behaviour:
Forwarding (combinational, every state):
- hit_mem_i = src_valid[i] & mem_valid & mem_regwrite & ~mem_is_load & (mem_rd == src_i).
- hit_wb_i = src_valid[i] & wb_regwrite & (wb_rd == src_i).
- MEM has priority over WB. fwd_en[i] = hit_mem_i | hit_wb_i.
- fwd_data_i = alu_result on hit_mem_i, else wb_result on hit_wb_i, else 0.
- R0 is not special.

FSM states: IDLE, LD_WAIT, BR_FLUSH. Internal counter cnt is 8 bits.

IDLE, priority order:
1. branch_taken:
 - flush[3:1]=1 this cycle; flush_count++.
 - If FLUSH_CYCLES>1, load cnt=FLUSH_CYCLES-2 and go to BR_FLUSH.
2. mem_valid & mem_is_load & LOAD_LAT>1:
 - stall[3:0]=1, flush[4]=1.
 - Load cnt=LOAD_LAT-2 and go to LD_WAIT.
3. Load-use (any i with src_valid[i] & mem_valid & mem_is_load & mem_regwrite & mem_rd==src_i):
 - stall[2:0]=1, flush[3]=1, single cycle.
 - The consumer then forwards from WB on the next cycle.
4. Otherwise all stall/flush bits are 0.

LD_WAIT:
- cnt!=0: stall[3:0]=1, flush[4]=1, cnt--.
- cnt==0 (release cycle): no latency stall; load-use rule 3 applies; next state IDLE.
- Total latency stall = LOAD_LAT-1 cycles.
- branch_taken is ignored in this state.

BR_FLUSH:
- flush[1]=1 each cycle.
- Load and load-use detection disabled.
- cnt==0 means next state IDLE, else cnt--.

Counters:
- stall_count increments each cycle any stall bit is 1.
- Both counters saturate at all-ones.

Reset:
- While rst=1, state=IDLE, cnt=0 and counters=0 on the clock edge.
- stall and flush are forced to 0 combinationally; fwd_en and fwd_data stay live.
- Reset mid-LD_WAIT or mid-BR_FLUSH aborts the sequence immediately.

Test Plan:
1. Forwarding priority: src0=1 (valid), mem_rd=1 with regwrite, alu_result=10, wb_rd=1, wb_result=2 -> fwd_en[0]=1, fwd_data0=10; drop mem_regwrite -> fwd_data0=2.
2. Load-use, LOAD_LAT=1: mem_is_load, mem_rd=2, src1=2 -> stall=00111, flush=01000 for exactly 1 cycle; next cycle with wb_rd=2, wb_result=7 -> fwd_data1=7.
3. Load latency, LOAD_LAT=3: load enters MEM -> stall=01111 and flush=10000 for 2 cycles, release on the 3rd; stall_count=2.
4. Branch, FLUSH_CYCLES=3: branch_taken pulse -> flush=01110, then 00010 for 2 cycles, then 0; flush_count=1; a load presented during BR_FLUSH causes no stall.
5. Reset mid-LD_WAIT (LOAD_LAT=4, rst asserted after 1 stall cycle) -> stall=0 during reset; after reset state is IDLE and counters read 0.
6. Saturation, CNT_W=2: hold a continuous load-latency stall for 5 cycles -> stall_count reaches 3 and holds.
